// File: rtl/tqvp_arb_pkg.sv
// Shared types and constants for the TinyQV register-port arbiter.
package tqvp_arb_pkg;
  typedef enum logic [1:0] {IDLE, ADDR, WAIT, DONE} arb_state_t;

  localparam int READ_LAT_MIN = 1;
  localparam int READ_LAT_MAX = 3;
  localparam int CNT_W        = 2;

  typedef logic req_idx_t;
endpackage

// File: rtl/tqvp_rr_arb2.sv
// Two-way round-robin pick, purely combinational.
// On a tie the requester that did not win last time is chosen.
import tqvp_arb_pkg::*;

module tqvp_rr_arb2 (
  input  logic     req0,
  input  logic     req1,
  input  req_idx_t last,
  output logic     valid,
  output req_idx_t winner
);
  assign valid  = req0 | req1;
  assign winner = (req0 && req1) ? ~last : req1;
endmodule

// File: rtl/tqvp_reg_arbiter.sv
// Arbitrates the TinyQV peripheral register port between two requesters.
// One transaction per READ_LAT+2 cycles; requests are sampled only in IDLE and wait otherwise.
import tqvp_arb_pkg::*;

module tqvp_reg_arbiter #(
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 8,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] data_in,
  output logic              data_write,
  input  logic [DATA_W-1:0] data_out,
  output logic              busy,
  output logic              grant_id
);
  arb_state_t        state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;
  req_idx_t          grant_q;
  logic              pick_valid;
  req_idx_t          pick;

  tqvp_rr_arb2 u_rr (
    .req0   (req0),
    .req1   (req1),
    .last   (grant_q),
    .valid  (pick_valid),
    .winner (pick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    data_write = 1'b0;
    ack0       = 1'b0;
    ack1       = 1'b0;
    rdata0     = rdata0_q;
    rdata1     = rdata1_q;
    case (state)
      IDLE: if (pick_valid) state_nxt = ADDR;
      ADDR: begin
        data_write = lat_we;
        state_nxt  = (READ_LAT == 1) ? DONE : WAIT;
      end
      // cnt==1 here means the decrement lands on zero this cycle
      WAIT: if (cnt == CNT_W'(1)) state_nxt = DONE;
      DONE: begin
        state_nxt = IDLE;
        if (grant_q) begin
          ack1   = 1'b1;
          rdata1 = data_out;
        end else begin
          ack0   = 1'b1;
          rdata0 = data_out;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_q   <= 1'b1;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      cnt       <= '0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      if (state == IDLE && pick_valid) begin
        grant_q   <= pick;
        lat_we    <= pick ? we1 : we0;
        lat_addr  <= pick ? addr1 : addr0;
        lat_wdata <= pick ? wdata1 : wdata0;
      end
      if (state == ADDR)      cnt <= CNT_W'(READ_LAT - 1);
      else if (state == WAIT) cnt <= cnt - CNT_W'(1);
      if (state == DONE) begin
        if (grant_q) rdata1_q <= data_out;
        else         rdata0_q <= data_out;
      end
    end
  end

  assign address  = lat_addr;
  assign data_in  = lat_wdata;
  assign busy     = (state != IDLE);
  assign grant_id = grant_q;
endmodule

// File: tb/tb_tqvp_reg_arbiter.sv
// Scoreboard bench for tqvp_reg_arbiter: READ_LAT=1 instance (a) and READ_LAT=3 instance (b).
module tb_tqvp_reg_arbiter;
  typedef struct {
    logic       id;
    logic       we;
    logic [3:0] addr;
    logic [7:0] wdata;
    logic [7:0] rexp;
  } txn_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Peripheral register contents after reset are a fixed function of address.
  function automatic logic [7:0] seed(input logic [3:0] a);
    return 8'h5A + {4'h0, a} - 8'h07;
  endfunction

  function automatic txn_t mk(input logic id, input logic we, input logic [3:0] addr,
                              input logic [7:0] wdata, input logic [7:0] rexp);
    txn_t t;
    t.id = id; t.we = we; t.addr = addr; t.wdata = wdata; t.rexp = rexp;
    return t;
  endfunction

  // ---------------- instance a: READ_LAT = 1 ----------------
  logic       req0, we0, req1, we1, ack0, ack1, data_write, busy, grant_id;
  logic [3:0] addr0, addr1, address;
  logic [7:0] wdata0, wdata1, rdata0, rdata1, data_in, data_out;
  logic [7:0] mem_a [16];

  tqvp_reg_arbiter #(.ADDR_W(4), .DATA_W(8), .READ_LAT(1)) u_dut_a (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
    .address(address), .data_in(data_in), .data_write(data_write), .data_out(data_out),
    .busy(busy), .grant_id(grant_id)
  );

  assign data_out = mem_a[address];
  always @(posedge clk or posedge rst) begin
    if (rst) for (int i = 0; i < 16; i++) mem_a[i] <= seed(4'(i));
    else if (data_write) mem_a[address] <= data_in;
  end

  // ---------------- instance b: READ_LAT = 3 ----------------
  logic       req0_b, we0_b, req1_b, we1_b, ack0_b, ack1_b, data_write_b, busy_b, grant_id_b;
  logic [3:0] addr0_b, addr1_b, address_b;
  logic [7:0] wdata0_b, wdata1_b, rdata0_b, rdata1_b, data_in_b, data_out_b;
  logic [7:0] mem_b [16];

  tqvp_reg_arbiter #(.ADDR_W(4), .DATA_W(8), .READ_LAT(3)) u_dut_b (
    .clk(clk), .rst(rst),
    .req0(req0_b), .we0(we0_b), .addr0(addr0_b), .wdata0(wdata0_b), .ack0(ack0_b), .rdata0(rdata0_b),
    .req1(req1_b), .we1(we1_b), .addr1(addr1_b), .wdata1(wdata1_b), .ack1(ack1_b), .rdata1(rdata1_b),
    .address(address_b), .data_in(data_in_b), .data_write(data_write_b), .data_out(data_out_b),
    .busy(busy_b), .grant_id(grant_id_b)
  );

  assign data_out_b = mem_b[address_b];
  always @(posedge clk or posedge rst) begin
    if (rst) for (int i = 0; i < 16; i++) mem_b[i] <= seed(4'(i));
    else if (data_write_b) mem_b[address_b] <= data_in_b;
  end

  // ---------------- scoreboards ----------------
  txn_t q_a[$];
  txn_t q_b[$];
  int   dw_a = 0, dw_b = 0, ack1_a_cnt = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (data_write) begin
        dw_a++;
        check_eq("a_wr_pending", q_a.size() > 0, 1);
        if (q_a.size() > 0) begin
          check_eq("a_wr_is_write", q_a[0].we, 1);
          check_eq("a_wr_addr", address, q_a[0].addr);
          check_eq("a_wr_data", data_in, q_a[0].wdata);
        end
      end
      if (ack1) ack1_a_cnt++;
      if (ack0 || ack1) begin
        check_eq("a_ack_onehot", ack0 & ack1, 0);
        check_eq("a_ack_pending", q_a.size() > 0, 1);
        if (q_a.size() > 0) begin
          txn_t t;
          t = q_a.pop_front();
          check_eq("a_ack_id", ack1, t.id);
          check_eq("a_grant_id", grant_id, t.id);
          check_eq("a_rdata", t.id ? rdata1 : rdata0, t.rexp);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (data_write_b) dw_b++;
      if (ack0_b || ack1_b) begin
        check_eq("b_ack_pending", q_b.size() > 0, 1);
        if (q_b.size() > 0) begin
          txn_t t;
          t = q_b.pop_front();
          check_eq("b_ack_id", ack1_b, t.id);
          check_eq("b_grant_id", grant_id_b, t.id);
          check_eq("b_rdata", t.id ? rdata1_b : rdata0_b, t.rexp);
        end
      end
    end
  end

  // ack_ks holds negedge indices (0 = IDLE cycle of the first request) of each ack.
  int ack_ks[$];

  task automatic run_a(input int nacks, input bit hold);
    int seen = 0;
    ack_ks.delete();
    for (int k = 0; k < 40 && seen < nacks; k++) begin
      @(negedge clk); #1;
      if (ack0 || ack1) begin
        seen++;
        ack_ks.push_back(k);
        if (!hold) begin
          if (ack0) req0 = 1'b0;
          if (ack1) req1 = 1'b0;
        end else if (seen == nacks) begin
          req0 = 1'b0;
          req1 = 1'b0;
        end
      end
    end
    check_eq("a_ack_count", seen, nacks);
    @(posedge clk); #1;
  endtask

  task automatic run_b(input logic [3:0] ea);
    int ack_k = -1;
    for (int k = 0; k < 20 && ack_k < 0; k++) begin
      @(negedge clk); #1;
      if (busy_b) check_eq("b_addr_stable", address_b, ea);
      if (ack0_b || ack1_b) begin
        ack_k  = k;
        req0_b = 1'b0;
        req1_b = 1'b0;
      end
    end
    check_eq("b_ack_latency", ack_k, 4);
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int dw0, a1;
    rst = 1'b1;
    {req0, we0, req1, we1, addr0, addr1, wdata0, wdata1} = '0;
    {req0_b, we0_b, req1_b, we1_b, addr0_b, addr1_b, wdata0_b, wdata1_b} = '0;
    #12;
    check_eq("rst_address", address, 0);
    check_eq("rst_data_in", data_in, 0);
    check_eq("rst_data_write", data_write, 0);
    check_eq("rst_acks", {ack0, ack1, ack0_b, ack1_b}, 0);
    check_eq("rst_rdata", {rdata0, rdata1}, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_grant_id", grant_id, 1);
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(posedge clk); #1;

    // single write from requester 0
    dw0 = dw_a; a1 = ack1_a_cnt;
    q_a.push_back(mk(1'b0, 1'b1, 4'h3, 8'hA5, 8'hA5));
    we0 = 1'b1; addr0 = 4'h3; wdata0 = 8'hA5; req0 = 1'b1;
    run_a(1, 1'b0);
    check_eq("wr_ack_latency", ack_ks.size() > 0 ? ack_ks[0] : -1, 2);
    check_eq("wr_strobe_cycles", dw_a - dw0, 1);
    check_eq("wr_no_ack1", ack1_a_cnt - a1, 0);

    // single read from requester 1
    dw0 = dw_a;
    q_a.push_back(mk(1'b1, 1'b0, 4'h7, 8'h00, 8'h5A));
    we1 = 1'b0; addr1 = 4'h7; req1 = 1'b1;
    run_a(1, 1'b0);
    check_eq("rd_ack_latency", ack_ks.size() > 0 ? ack_ks[0] : -1, 2);
    check_eq("rd_no_strobe", dw_a - dw0, 0);
    repeat (3) @(negedge clk);
    check_eq("rd_rdata1_held", rdata1, 8'h5A);
    check_eq("rd_rdata0_held", rdata0, 8'hA5);
    @(posedge clk); #1;

    // both requesters held high right after reset: strict alternation 0,1,0,1
    rst = 1'b1; #3 rst = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      q_a.push_back(mk(1'b0, 1'b1, 4'h2, 8'h3C, 8'h3C));
      q_a.push_back(mk(1'b1, 1'b0, 4'h9, 8'h00, seed(4'h9)));
    end
    we0 = 1'b1; addr0 = 4'h2; wdata0 = 8'h3C;
    we1 = 1'b0; addr1 = 4'h9;
    req0 = 1'b1; req1 = 1'b1;
    run_a(4, 1'b1);
    for (int i = 1; i < 4; i++)
      check_eq("rr_ack_spacing", ack_ks.size() > i ? ack_ks[i] - ack_ks[i-1] : -1, 3);

    // reset during the ADDR cycle of a write
    q_a.push_back(mk(1'b0, 1'b1, 4'h5, 8'h77, 8'h77));
    we0 = 1'b1; addr0 = 4'h5; wdata0 = 8'h77; req0 = 1'b1;
    for (int k = 0; k < 6 && !data_write; k++) @(negedge clk);
    check_eq("abort_reached_addr", data_write, 1);
    #2 rst = 1'b1;
    #1;
    check_eq("abort_data_write", data_write, 0);
    check_eq("abort_ack", {ack0, ack1}, 0);
    check_eq("abort_busy", busy, 0);
    check_eq("abort_address", address, 0);
    check_eq("abort_grant_id", grant_id, 1);
    req0 = 1'b0;
    q_a.delete();
    @(posedge clk); #1 rst = 1'b0;
    q_a.push_back(mk(1'b0, 1'b1, 4'h5, 8'h77, 8'h77));
    q_a.push_back(mk(1'b1, 1'b0, 4'h9, 8'h00, seed(4'h9)));
    req0 = 1'b1; req1 = 1'b1;
    run_a(2, 1'b0);
    check_eq("reissue_latency", ack_ks.size() > 0 ? ack_ks[0] : -1, 2);

    // READ_LAT = 3: read then write on instance b
    q_b.push_back(mk(1'b1, 1'b0, 4'h4, 8'h00, seed(4'h4)));
    we1_b = 1'b0; addr1_b = 4'h4; req1_b = 1'b1;
    run_b(4'h4);
    check_eq("b_rd_no_strobe", dw_b, 0);
    q_b.push_back(mk(1'b0, 1'b1, 4'h6, 8'hC7, 8'hC7));
    we0_b = 1'b1; addr0_b = 4'h6; wdata0_b = 8'hC7; req0_b = 1'b1;
    run_b(4'h6);
    check_eq("b_wr_strobe_cycles", dw_b, 1);

    repeat (3) @(posedge clk);
    check_eq("a_sb_drained", q_a.size(), 0);
    check_eq("b_sb_drained", q_b.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/tqvp_reg_arbiter.md
# tqvp_reg_arbiter

Arbitrates the TinyQV peripheral register port (`address`, `data_write`, `data_in`, `data_out`) between two independent requesters, e.g. the SPI register bridge and an on-chip configuration sequencer. Each access runs as a single transaction: address phase, optional write strobe, read-data capture, then acknowledge. Ties are broken round-robin. The block sits between the requesters and the peripheral under test in the test harness.

## Interface

Parameters:
- `ADDR_W`, 4: register address width.
- `DATA_W`, 8: register data width.
- `READ_LAT`, 1: cycles from address valid to `data_out` sample. Legal range is 1..3.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req0`  in  1  requester 0 transaction request. Level; held until `ack0`.
- `we0`  in  1  requester 0 write (1) / read (0). Stable while `req0`.
- `addr0`  in  ADDR_W  requester 0 address. Stable while `req0`.
- `wdata0`  in  DATA_W  requester 0 write data. Stable while `req0`.
- `ack0`  out  1  one-cycle completion pulse.
- `rdata0`  out  DATA_W  captured `data_out`. Valid in the `ack0` cycle and held until the next requester-0 ack.
- `req1`, `we1`, `addr1`, `wdata1`, `ack1`, `rdata1`: identical set for requester 1.
- `address`  out  ADDR_W  to peripheral.
- `data_in`  out  DATA_W  to peripheral, write data.
- `data_write`  out  1  to peripheral, one-cycle write strobe.
- `data_out`  in  DATA_W  from peripheral, combinational function of `address`.
- `busy`  out  1  high in any state other than IDLE.
- `grant_id`  out  1  index of the current or last granted requester.

## Operation

- FSM states: IDLE, ADDR, WAIT, DONE.
- **IDLE**
  - Sample `req0`/`req1`.
  - If exactly one is high, grant it.
  - If both are high, grant the one that is not `grant_id` (round-robin).
  - Latch the winner's `we`/`addr`/`wdata` into internal registers.
  - Go to ADDR.
- **ADDR**
  - `address` and `data_in` are driven from the latched values.
  - `data_write` = latched `we` for this single cycle.
  - Load the wait counter with `READ_LAT-1`.
  - Go to WAIT, or to DONE if `READ_LAT`=1.
- **WAIT**
  - Decrement the counter; `address` is held.
  - Go to DONE when the counter is 0.
- **DONE**
  - Capture `data_out` into `rdata<grant_id>`.
  - Pulse `ack<grant_id>`.
  - Return to IDLE.
  - Reads and writes both capture; write acks return post-write read-back.
- Requesters are sampled only in IDLE. A request arriving mid-transaction waits.
- A requester dropping `req` before ack is a protocol violation. The transaction still completes and the ack is still issued.
- A requester must deassert `req` in the cycle after `ack`, or it re-enters arbitration as a new request.
- `address`/`data_in` hold their last values in IDLE. `data_write` is never high outside ADDR.

## Timing

- Reset values:
  - state = IDLE
  - `grant_id`=1, so requester 0 wins the first tie
  - `address`=0, `data_in`=0
  - `data_write`=0, `ack0`=`ack1`=0
  - `rdata0`=`rdata1`=0
  - `busy`=0
- Latency: `req` seen in IDLE at cycle N → ADDR at N+1 → DONE (ack) at N+1+`READ_LAT`.
- Transaction length is `READ_LAT`+2 cycles including IDLE.
- Back-to-back throughput: one transaction per `READ_LAT`+2 cycles.
- Both requesters continuously high: grants strictly alternate 0,1,0,1…
- `rst` asserted mid-transaction:
  - All outputs reach their reset values asynchronously.
  - A `data_write` in progress is cut short.
  - No ack is issued for the aborted transaction; the requester must reissue.
- `grant_id` updates in the IDLE→ADDR transition and holds otherwise.

## Structure

- Package `tqvp_arb_pkg`:
  - state enum `arb_state_t` {IDLE, ADDR, WAIT, DONE}
  - `READ_LAT` legal-range constants
  - requester-index typedef.
- Sub-module `tqvp_rr_arb2`: combinational two-way round-robin pick. Inputs `req0`, `req1`, `last`; outputs `valid`, `winner`.
- Counter and FSM stay in the top module.

## Test plan

- **Single write:** `req0`, `we0`=1, `addr0`=4'h3, `wdata0`=8'hA5 → `address`=3 and `data_in`=A5 with `data_write`=1 exactly 1 cycle; `ack0` at N+2 (`READ_LAT`=1); `ack1` never.
- **Single read:** peripheral returns 8'h5A at addr 4'h7; `req1` read → `rdata1`=5A in the `ack1` cycle and held afterwards; `data_write` stays 0.
- **Simultaneous requests after reset:** `req0`+`req1` both high → order 0,1,0,1 over 4 transactions; `grant_id` toggles accordingly.
- **`READ_LAT`=3:** read issued at cycle N → `address` stable N+1..N+3, ack at N+4, captured value equals `data_out` at N+4.
- **Reset mid-transaction:** assert `rst` during ADDR of a write → `data_write` drops immediately, no ack; after release, the reissued request completes normally with requester 0 winning the first tie.
